// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - request/result bundle between the EX stage and seq_alu
interface seq_alu_if #(
    parameter int W  = 32,
    parameter int SW = 5
);
    logic          start;
    logic [5:0]    ctrl;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] shamt;
    logic          busy;
    logic          done;
    logic [W-1:0]  r;
    logic [W-1:0]  r2;
    logic          z;
    logic          ovf;
    logic          div0;

    modport master (
        output start, ctrl, a, b, shamt,
        input  busy, done, r, r2, z, ovf, div0
    );

    modport slave (
        input  start, ctrl, a, b, shamt,
        output busy, done, r, r2, z, ovf, div0
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU: single-cycle logic/shift ops, iterative mul/div, HI/LO
module seq_alu #(
    parameter int W  = 32,
    parameter int SW = 5
) (
    input logic    clk,
    input logic    rst_n,
    seq_alu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  hi, lo, r_q, r2_q, opa, opb, ma, mb;
    logic [2*W-1:0] p;
    logic [SW:0]   cnt;
    logic          done_q, z_q, ovf_q, div0_q;
    logic          op_div, op_sgn, neg_q, neg_r;

    logic accept, is_md, div_zero_in;
    assign accept      = bus.start && (state == IDLE || state == FIX);
    assign is_md       = (bus.ctrl[5:2] == 4'b0100);
    assign div_zero_in = (bus.ctrl[5:1] == 5'b01001) && (bus.b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // FIX is the done cycle, so it accepts a new request exactly like IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FIX: begin
                state_nx = IDLE;
                if (accept && is_md && !div_zero_in) state_nx = PREP;
            end
            PREP:    state_nx = ITER;
            ITER:    if (cnt == (SW+1)'(1)) state_nx = FIX;
            default: state_nx = IDLE;
        endcase
    end

    logic [W-1:0] sum, diff, sc_r;
    logic         sc_ovf;
    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;

    always_comb begin
        sc_r   = '0;
        sc_ovf = 1'b0;
        case (bus.ctrl)
            6'h00: sc_r = bus.a & bus.b;
            6'h01: sc_r = bus.a | bus.b;
            6'h02: begin
                sc_r   = sum;
                sc_ovf = (bus.a[W-1] == bus.b[W-1]) && (sum[W-1] != bus.a[W-1]);
            end
            6'h03: sc_r = sum;
            6'h04: sc_r = bus.a ^ bus.b;
            6'h05: sc_r = ~(bus.a | bus.b);
            6'h06: begin
                sc_r   = diff;
                sc_ovf = (bus.a[W-1] != bus.b[W-1]) && (diff[W-1] != bus.a[W-1]);
            end
            6'h07: sc_r = diff;
            6'h08: sc_r = {{(W-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            6'h09: sc_r = {{(W-1){1'b0}}, (bus.a < bus.b)};
            6'h0A: sc_r = bus.b << bus.shamt;
            6'h0B: sc_r = bus.b >> bus.shamt;
            6'h0C: sc_r = $signed(bus.b) >>> bus.shamt;
            6'h0D: sc_r = bus.b << (W/2);
            6'h18: sc_r = hi;
            6'h19: sc_r = lo;
            default: sc_r = '0;
        endcase
    end

    // Magnitudes for the iteration; signed ops work on |a|, |b| and fix signs at the end
    logic [W-1:0] absa, absb;
    assign absa = (op_sgn && opa[W-1]) ? (~opa + 1'b1) : opa;
    assign absb = (op_sgn && opb[W-1]) ? (~opb + 1'b1) : opb;

    // p = {HI-accumulator/remainder, multiplier/quotient}
    logic [W:0]     msum, rsh, rdf;
    logic [2*W-1:0] p_nx, prod;
    logic [W-1:0]   quot, remv, fin_lo, fin_hi;
    logic           ge;
    assign msum = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, ma} : '0);
    assign rsh  = {p[2*W-1:W], p[W-1]};
    assign rdf  = rsh - {1'b0, mb};
    assign ge   = !rdf[W];
    assign p_nx = op_div ? {(ge ? rdf[W-1:0] : rsh[W-1:0]), p[W-2:0], ge}
                         : {msum, p[W-1:1]};
    assign prod   = neg_q ? (~p_nx + 1'b1) : p_nx;
    assign quot   = neg_q ? (~p_nx[W-1:0] + 1'b1) : p_nx[W-1:0];
    assign remv   = neg_r ? (~p_nx[2*W-1:W] + 1'b1) : p_nx[2*W-1:W];
    assign fin_lo = op_div ? quot : prod[W-1:0];
    assign fin_hi = op_div ? remv : prod[2*W-1:W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0; lo <= '0; r_q <= '0; r2_q <= '0;
            opa <= '0; opb <= '0; ma <= '0; mb <= '0; p <= '0; cnt <= '0;
            done_q <= 1'b0; z_q <= 1'b1; ovf_q <= 1'b0; div0_q <= 1'b0;
            op_div <= 1'b0; op_sgn <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                op_div <= bus.ctrl[1];
                op_sgn <= !bus.ctrl[0];
                opa    <= bus.a;
                opb    <= bus.b;
                if (!is_md) begin
                    done_q <= 1'b1;
                    r_q    <= sc_r;
                    r2_q   <= '0;
                    z_q    <= (sc_r == '0);
                    ovf_q  <= sc_ovf;
                    div0_q <= 1'b0;
                end else if (div_zero_in) begin
                    done_q <= 1'b1;
                    r_q    <= '1;
                    r2_q   <= bus.a;
                    lo     <= '1;
                    hi     <= bus.a;
                    z_q    <= 1'b0;
                    ovf_q  <= 1'b0;
                    div0_q <= 1'b1;
                end
            end
            case (state)
                PREP: begin
                    ma    <= absa;
                    mb    <= absb;
                    neg_q <= op_sgn && (opa[W-1] ^ opb[W-1]);
                    neg_r <= op_sgn && opa[W-1];
                    p     <= {{W{1'b0}}, (op_div ? absa : absb)};
                    cnt   <= (SW+1)'(W);
                end
                ITER: begin
                    p   <= p_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == (SW+1)'(1)) begin
                        done_q <= 1'b1;
                        r_q    <= fin_lo;
                        r2_q   <= fin_hi;
                        lo     <= fin_lo;
                        hi     <= fin_hi;
                        z_q    <= (fin_lo == '0);
                        ovf_q  <= 1'b0;
                        div0_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == PREP) || (state == ITER);
    assign bus.done = done_q;
    assign bus.r    = r_q;
    assign bus.r2   = r2_q;
    assign bus.z    = z_q;
    assign bus.ovf  = ovf_q;
    assign bus.div0 = div0_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized and directed checks of seq_alu against an arithmetic model
module tb_seq_alu;
    localparam int W  = 32;
    localparam int SW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_alu_if #(.W(W), .SW(SW)) bus ();
    seq_alu #(.W(W), .SW(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] er, output logic [31:0] er2,
                         output logic eo, output logic ed, output int lat);
        longint sa, sb, s, q, rm;
        logic [63:0] pr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        er = '0; er2 = '0; eo = 1'b0; ed = 1'b0; lat = 1;
        case (c)
            6'h00: er = a & b;
            6'h01: er = a | b;
            6'h02: begin s = sa + sb; er = a + b; eo = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            6'h03: er = a + b;
            6'h04: er = a ^ b;
            6'h05: er = ~(a | b);
            6'h06: begin s = sa - sb; er = a - b; eo = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            6'h07: er = a - b;
            6'h08: er = (sa < sb) ? 32'd1 : 32'd0;
            6'h09: er = (a < b) ? 32'd1 : 32'd0;
            6'h0A: er = b << sh;
            6'h0B: er = b >> sh;
            6'h0C: er = 32'(sb >>> sh);
            6'h0D: er = b << 16;
            6'h18: er = m_hi;
            6'h19: er = m_lo;
            6'h10, 6'h11: begin
                if (c == 6'h10) pr = 64'(sa * sb);
                else            pr = 64'(a) * 64'(b);
                m_hi = pr[63:32]; m_lo = pr[31:0];
                er = m_lo; er2 = m_hi; lat = W + 2;
            end
            6'h12, 6'h13: begin
                if (b == 32'd0) begin
                    m_lo = '1; m_hi = a; ed = 1'b1;
                end else begin
                    if (c == 6'h12) begin q = sa / sb; rm = sa % sb; end
                    else begin q = longint'(a) / longint'(b); rm = longint'(a) % longint'(b); end
                    m_lo = 32'(q); m_hi = 32'(rm); lat = W + 2;
                end
                er = m_lo; er2 = m_hi;
            end
            default: er = '0;
        endcase
    endtask

    task automatic do_op(input logic [5:0] c, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] sh, input bit inj);
        logic [31:0] er, er2;
        logic eo, ed;
        int lat, edges, bcnt;
        model(c, av, bv, sh, er, er2, eo, ed, lat);
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = c; bus.a = av; bus.b = bv; bus.shamt = sh;
        @(posedge clk); #1;
        bus.start = 1'b0;
        edges = 1; bcnt = 0;
        while (!bus.done && edges < 80) begin
            if (bus.busy) bcnt++;
            if (inj && edges < 10) begin bus.start = 1'b1; bus.ctrl = 6'h02; end
            else bus.start = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        bus.start = 1'b0;
        chk($sformatf("lat_%h", c), 64'(edges), 64'(lat));
        chk($sformatf("r_%h", c), 64'(bus.r), 64'(er));
        chk($sformatf("r2_%h", c), 64'(bus.r2), 64'(er2));
        chk($sformatf("z_%h", c), 64'(bus.z), 64'(er == 32'd0));
        chk($sformatf("ovf_%h", c), 64'(bus.ovf), 64'(eo));
        chk($sformatf("div0_%h", c), 64'(bus.div0), 64'(ed));
        chk($sformatf("busycnt_%h", c), 64'(bcnt), 64'(lat - 1));
        chk($sformatf("busy_at_done_%h", c), 64'(bus.busy), 64'd0);
    endtask

    logic [5:0] codes [22] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                               6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h18, 6'h19,
                               6'h10, 6'h11, 6'h12, 6'h13, 6'h0E, 6'h3F};

    initial begin
        int seen;
        logic [31:0] ra, rb;
        logic [5:0] rc;
        bus.start = 1'b0; bus.ctrl = '0; bus.a = '0; bus.b = '0; bus.shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_r", 64'(bus.r), 64'd0);
        chk("rst_r2", 64'(bus.r2), 64'd0);
        chk("rst_z", 64'(bus.z), 64'd1);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        chk("rst_div0", 64'(bus.div0), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        do_op(6'h18, 32'h0, 32'h0, 5'd0, 1'b0);
        do_op(6'h02, 32'h7FFFFFFF, 32'h1, 5'd0, 1'b0);
        do_op(6'h0C, 32'h0, 32'h80000000, 5'd31, 1'b0);
        do_op(6'h06, 32'h80000000, 32'h1, 5'd0, 1'b0);
        do_op(6'h03, 32'hFFFFFFFF, 32'h1, 5'd0, 1'b0);
        do_op(6'h10, 32'hFFFFFFFD, 32'h7, 5'd0, 1'b0);
        do_op(6'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0);
        do_op(6'h12, 32'hFFFFFFF9, 32'h2, 5'd0, 1'b0);
        do_op(6'h12, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b0);
        do_op(6'h13, 32'h1234, 32'h0, 5'd0, 1'b0);
        do_op(6'h11, 32'h3, 32'h5, 5'd0, 1'b1);
        do_op(6'h18, 32'h0, 32'h0, 5'd0, 1'b0);
        do_op(6'h19, 32'h0, 32'h0, 5'd0, 1'b0);
        do_op(6'h3F, 32'h1, 32'h2, 5'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rc = codes[$urandom_range(0, 21)];
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
            do_op(rc, ra, rb, 5'($urandom_range(0, 31)), 1'b0);
        end

        do_op(6'h11, 32'h12345, 32'h6789, 5'd0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.ctrl = 6'h12; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        chk("mid_rst_r", 64'(bus.r), 64'd0);
        chk("mid_rst_r2", 64'(bus.r2), 64'd0);
        chk("mid_rst_z", 64'(bus.z), 64'd1);
        m_hi = '0; m_lo = '0;
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        chk("no_done_after_rst", 64'(seen), 64'd0);
        do_op(6'h18, 32'h0, 32'h0, 5'd0, 1'b0);
        do_op(6'h19, 32'h0, 32'h0, 5'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
